// File: rtl/serial_link_pkg.sv
// Shared serial-link types and constants for the RX half-word aligner.
package serial_link_pkg;

    localparam int unsigned PhyLanes = 8;
    localparam logic [2*PhyLanes-1:0] TrainPattern = 16'hA55A;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_e;

    typedef enum logic {
        UPPER = 1'b0,
        LOWER = 1'b1
    } align_phase_e;

    typedef logic [PhyLanes-1:0]   phy_half_t;
    typedef logic [2*PhyLanes-1:0] phy_data_t;

endpackage

// File: rtl/serial_link_rx_ddr_aligner.sv
// Pairs DDR half-words into full PHY words, aligning on a repeated training word
// so the first-sent upper half always lands in the top of data_o.
module serial_link_rx_ddr_aligner #(
    parameter int unsigned           NumLanes     = 8,
    parameter logic [2*NumLanes-1:0] TrainPattern = serial_link_pkg::TrainPattern,
    parameter int unsigned           LockCount    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumLanes-1:0]     in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [2*NumLanes-1:0]   data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    input  logic                    relock_i,
    output logic                    locked_o
);
    import serial_link_pkg::*;

    localparam logic [3:0] LockMax = 4'(LockCount);
    localparam logic [3:0] LockLast = 4'(LockCount - 1);

    if (TrainPattern[2*NumLanes-1:NumLanes] == TrainPattern[NumLanes-1:0]) begin : g_bad_pattern
        $error("TrainPattern halves must differ");
    end
    if ((LockCount < 1) || (LockCount > 15)) begin : g_bad_lock_count
        $error("LockCount must be in 1..15");
    end

    align_state_e          r_state;
    align_state_e          w_state_next;
    align_phase_e          r_phase;
    logic [NumLanes-1:0]   r_prev;
    logic [NumLanes-1:0]   r_hi;
    logic                  r_skip;
    logic [3:0]            r_match_cnt;
    logic [2*NumLanes-1:0] r_data;
    logic                  r_valid;
    logic                  r_locked;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_match;
    logic                  w_lock_hit;
    logic                  w_load;

    assign w_accept   = in_valid_i & w_in_ready;
    assign w_match    = ({r_prev, in_data_i} == TrainPattern);
    // The half completing the final required match; a same-cycle relock wins.
    assign w_lock_hit = (r_state == SEARCH) & w_accept & ~relock_i & ~r_skip & w_match
                        & (r_match_cnt >= LockLast);
    assign w_load     = (r_state == LOCKED) & w_accept & ~relock_i & (r_phase == LOWER);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEARCH: begin
                if (w_lock_hit) begin
                    w_state_next = LOCKED;
                end else begin
                    w_state_next = SEARCH;
                end
            end
            LOCKED: begin
                if (relock_i) begin
                    w_state_next = SEARCH;
                end else begin
                    w_state_next = LOCKED;
                end
            end
            default: w_state_next = SEARCH;
        endcase
    end

    // Input ready: only the lower half of a locked word waits on the output slot.
    always_comb begin
        w_in_ready = 1'b1;
        case (r_state)
            SEARCH: w_in_ready = 1'b1;
            LOCKED: begin
                if (r_phase == UPPER) begin
                    w_in_ready = 1'b1;
                end else begin
                    w_in_ready = ~r_valid | ready_i;
                end
            end
            default: w_in_ready = 1'b1;
        endcase
    end

    // Training search: shift register, 2-half spacing and saturating match count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prev      <= {NumLanes{1'b0}};
            r_skip      <= 1'b0;
            r_match_cnt <= 4'd0;
        end else if (relock_i) begin
            r_prev      <= {NumLanes{1'b0}};
            r_skip      <= 1'b0;
            r_match_cnt <= 4'd0;
        end else if ((r_state == SEARCH) && w_accept) begin
            r_prev <= in_data_i;
            if (r_skip) begin
                r_skip <= 1'b0;
            end else if (w_match) begin
                r_skip <= 1'b1;
                if (r_match_cnt < LockMax) begin
                    r_match_cnt <= r_match_cnt + 4'd1;
                end
            end else begin
                r_match_cnt <= 4'd0;
            end
        end
    end

    // Locked pairing: capture the upper half, then emit on the lower half.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_phase <= UPPER;
            r_hi    <= {NumLanes{1'b0}};
        end else if (relock_i || w_lock_hit) begin
            r_phase <= UPPER;
        end else if ((r_state == LOCKED) && w_accept) begin
            if (r_phase == UPPER) begin
                r_hi    <= in_data_i;
                r_phase <= LOWER;
            end else begin
                r_phase <= UPPER;
            end
        end
    end

    // Output word register; a pending word survives a relock until handshaked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data  <= {(2*NumLanes){1'b0}};
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= {r_hi, in_data_i};
            r_valid <= 1'b1;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Lock indicator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_locked <= 1'b0;
        end else if (relock_i) begin
            r_locked <= 1'b0;
        end else if (w_lock_hit) begin
            r_locked <= 1'b1;
        end
    end

    assign in_ready_o = w_in_ready;
    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign locked_o   = r_locked;

endmodule

// File: tb/tb_serial_link_rx_ddr_aligner.sv
// Directed plus randomized bench for the DDR half-word aligner against a
// stream-level reference model (lock = last 2*LockCount halves form the pattern).
module tb_serial_link_rx_ddr_aligner;

    localparam int unsigned NL = 8;
    localparam logic [15:0] TP = 16'hA55A;
    localparam int unsigned LC = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        relock_i = 1'b0;
    logic        locked_o;

    always #5 clk = ~clk;

    serial_link_rx_ddr_aligner #(
        .NumLanes    (NL),
        .TrainPattern(TP),
        .LockCount   (LC)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .in_data_i (in_data_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .relock_i  (relock_i),
        .locked_o  (locked_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_locked;
    bit         m_upper;
    bit         m_valid;
    logic [7:0] m_hi;
    logic [15:0] m_data;
    logic [7:0] m_hist[$];
    logic [7:0] src[$];
    int         words_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_ready(input bit rdy);
        return !m_locked || m_upper || !m_valid || rdy;
    endfunction

    function automatic bit hist_locks();
        int n;
        logic [7:0] e;
        n = m_hist.size();
        if (n < 2*LC) return 1'b0;
        for (int i = 0; i < 2*LC; i++) begin
            e = (i % 2 == 0) ? TP[15:8] : TP[7:0];
            if (m_hist[n - 2*LC + i] != e) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_upper  = 1'b1;
        m_valid  = 1'b0;
        m_hi     = 8'h00;
        m_data   = 16'h0000;
        m_hist.delete();
    endtask

    task automatic push_b(input logic [7:0] b);
        src.push_back(b);
    endtask

    task automatic push_train(input int n);
        for (int i = 0; i < n; i++) begin
            src.push_back(TP[15:8]);
            src.push_back(TP[7:0]);
        end
    endtask

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic cycle(input bit v_en, input bit rdy, input bit rel);
        bit acc;
        bit hs;
        bit mr;
        logic [7:0] d;
        logic [7:0] dummy;
        check_val("locked_o", {31'd0, locked_o}, {31'd0, m_locked});
        check_val("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
        check_val("data_o", {16'd0, data_o}, {16'd0, m_data});
        d = (src.size() > 0) ? src[0] : 8'($urandom);
        in_valid_i = v_en && (src.size() > 0);
        in_data_i  = d;
        ready_i    = rdy;
        relock_i   = rel;
        #1;
        mr = model_ready(rdy);
        check_val("in_ready_o", {31'd0, in_ready_o}, {31'd0, mr});
        acc = in_valid_i && mr;
        hs  = m_valid && rdy;
        if (hs) words_seen++;
        if (acc) dummy = src.pop_front();
        if (!m_locked) begin
            if (rel) begin
                m_hist.delete();
            end else if (acc) begin
                m_hist.push_back(d);
                if (m_hist.size() > 2*LC) dummy = m_hist.pop_front();
                if (hist_locks()) begin
                    m_locked = 1'b1;
                    m_upper  = 1'b1;
                    m_hist.delete();
                end
            end
            if (hs) m_valid = 1'b0;
        end else begin
            if (rel) begin
                m_locked = 1'b0;
                m_upper  = 1'b1;
                m_hist.delete();
                if (hs) m_valid = 1'b0;
            end else if (acc && m_upper) begin
                m_hi    = d;
                m_upper = 1'b0;
                if (hs) m_valid = 1'b0;
            end else if (acc) begin
                m_data  = {m_hi, d};
                m_valid = 1'b1;
                m_upper = 1'b1;
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, rdy, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        rst_ni     = 1'b0;
        in_valid_i = 1'b0;
        relock_i   = 1'b0;
        ready_i    = 1'b0;
        #1;
        check_val("rst_locked", {31'd0, locked_o}, 32'd0);
        check_val("rst_valid", {31'd0, valid_o}, 32'd0);
        check_val("rst_data", {16'd0, data_o}, 32'd0);
        model_reset();
        src.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        int w0;
        model_reset();
        words_seen = 0;
        @(negedge clk);
        do_reset();

        // Aligned training then one word
        push_train(4);
        push_b(8'h12); push_b(8'h34);
        run(14, 1'b1);

        // Backpressure: 1234 held, 78 stalled until ready
        push_b(8'h12); push_b(8'h34); push_b(8'h56); push_b(8'h78);
        run(6, 1'b0);
        check_val("bp_78_stalled", src.size(), 32'd1);
        run(4, 1'b1);

        // Relock while 1234 pending; 56 dropped
        push_b(8'h12); push_b(8'h34);
        run(3, 1'b0);
        push_b(8'h56);
        cycle(1'b1, 1'b0, 1'b1);
        w0 = words_seen;
        run(3, 1'b1);
        check_val("relock_pending_delivered", words_seen - w0, 32'd1);
        push_train(4);
        run(10, 1'b1);

        // Misaligned start
        cycle(1'b0, 1'b1, 1'b1);
        push_b(8'h00); push_train(4); push_b(8'h12); push_b(8'h34);
        run(14, 1'b1);

        // Broken run
        cycle(1'b0, 1'b1, 1'b1);
        push_b(8'hA5); push_b(8'h5A); push_b(8'hA5); push_b(8'h5A); push_b(8'hFF);
        push_train(4); push_b(8'h12); push_b(8'h34);
        run(20, 1'b1);

        // Reset after the upper half, then no word until retrained
        push_b(8'h12);
        cycle(1'b1, 1'b1, 1'b0);
        do_reset();
        push_b(8'h34); push_b(8'h56); push_b(8'h78); push_b(8'h9A);
        w0 = words_seen;
        run(8, 1'b1);
        check_val("no_word_after_reset", words_seen - w0, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (src.size() < 4) begin
                case ($urandom_range(0, 3))
                    0: begin
                        if ($urandom_range(0, 1) == 1) push_b(8'($urandom));
                        push_train(int'($urandom_range(3, 5)));
                    end
                    1: begin
                        push_b(TP[15:8]); push_b(TP[7:0]); push_b(8'($urandom));
                    end
                    default: begin
                        for (int k = 0; k < 6; k++) push_b(8'($urandom));
                    end
                endcase
            end
            if (i == 2000) do_reset();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 96) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
